dequantize_row: RTL and testbench

DEQUANTIZE_ROW -- requirements
Module: dequantize_row

---
 rtl/dequantize_row_if.sv | 23 ++
 rtl/dequantize_row.sv | 147 ++++++++++++++
 tb/tb_dequantize_row.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dequantize_row_if.sv
// Row handshake bundle for dequantize_row: quantized rows in, dequantized rows out.
interface dequantize_row_if;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] quantized_in;
  logic        is_luminance;
  logic        quantize_off;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] dct_coeffs_out;
  logic [7:0]  out_row;
  logic        block_done;

  modport master (
    output in_valid, quantized_in, is_luminance, quantize_off, out_ready,
    input  in_ready, out_valid, dct_coeffs_out, out_row, block_done
  );

  modport slave (
    input  in_valid, quantized_in, is_luminance, quantize_off, out_ready,
    output in_ready, out_valid, dct_coeffs_out, out_row, block_done
  );
endinterface

// File: rtl/dequantize_row.sv
// JPEG row dequantizer: 8 signed 10-bit coefficients x Annex K table row -> 8 signed 12-bit.
// Define DEQUANT_SATURATE_EN to clamp products to 12 bits; otherwise they wrap.
module dequantize_row (
  input  logic            clock,
  input  logic            reset_n,
  dequantize_row_if.slave bus
);

  localparam logic [7:0] LUMA_Q [64] = '{
    16,  11,  10,  16,  24,  40,  51,  61,
    12,  12,  14,  19,  26,  58,  60,  55,
    14,  13,  16,  24,  40,  57,  69,  56,
    14,  17,  22,  29,  51,  87,  80,  62,
    18,  22,  37,  56,  68, 109, 103,  77,
    24,  35,  55,  64,  81, 104, 113,  92,
    49,  64,  78,  87, 103, 121, 120, 101,
    72,  92,  95,  98, 112, 100, 103,  99
  };

  localparam logic [7:0] CHROMA_Q [64] = '{
    17,  18,  24,  47,  99,  99,  99,  99,
    18,  21,  26,  66,  99,  99,  99,  99,
    24,  26,  56,  99,  99,  99,  99,  99,
    47,  66,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99,
    99,  99,  99,  99,  99,  99,  99,  99
  };

  logic [2:0]       in_row;
  logic             lat_luma;
  logic             lat_bypass;

  logic             s1_valid;
  logic [79:0]      s1_data;
  logic [7:0][7:0]  s1_q;
  logic [2:0]       s1_row;
  logic             s1_bypass;

  logic             s2_valid;
  logic [95:0]      s2_data;
  logic [2:0]       s2_row;

  logic             s2_adv;
  logic             s1_free;
  logic             in_fire;
  logic             eff_luma;
  logic             eff_bypass;
  logic [7:0][7:0]  tbl_row;
  logic [5:0]       tbl_idx;
  logic signed [17:0] coef;
  logic signed [17:0] qent;
  logic signed [17:0] prod;
  logic [11:0]      narrow;
  logic [95:0]      s2_next;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_free      = !s1_valid || s2_adv;
  assign bus.in_ready = reset_n && s1_free;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Row 0 takes its modes straight from the ports; rows 1..7 reuse the copy latched on row 0
  assign eff_luma   = (in_row == 3'd0) ? bus.is_luminance : lat_luma;
  assign eff_bypass = (in_row == 3'd0) ? bus.quantize_off : lat_bypass;

  always_comb begin
    tbl_row = '0;
    tbl_idx = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      tbl_idx    = {in_row, 3'(k)};
      tbl_row[k] = eff_luma ? LUMA_Q[tbl_idx] : CHROMA_Q[tbl_idx];
    end
  end

  always_comb begin
    s2_next = '0;
    coef    = '0;
    qent    = '0;
    prod    = '0;
    narrow  = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      coef = {{8{s1_data[10*k+9]}}, s1_data[10*k +: 10]};
      qent = {10'b0, s1_q[k]};
      prod = coef * qent;
`ifdef DEQUANT_SATURATE_EN
      if (prod > 18'sd2047)
        narrow = 12'h7FF;
      else if (prod < -18'sd2048)
        narrow = 12'h800;
      else
        narrow = prod[11:0];
`else
      narrow = prod[11:0];
`endif
      if (s1_bypass)
        narrow = {{2{s1_data[10*k+9]}}, s1_data[10*k +: 10]};
      s2_next[12*k +: 12] = narrow;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_row     <= '0;
      lat_luma   <= 1'b0;
      lat_bypass <= 1'b0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_q       <= '0;
      s1_row     <= '0;
      s1_bypass  <= 1'b0;
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      s2_row     <= '0;
    end else begin
      if (in_fire) begin
        in_row <= in_row + 3'd1;
        if (in_row == 3'd0) begin
          lat_luma   <= bus.is_luminance;
          lat_bypass <= bus.quantize_off;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s2_next;
          s2_row  <= s1_row;
        end
      end
      if (s1_free) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_data   <= bus.quantized_in;
          s1_q      <= tbl_row;
          s1_row    <= in_row;
          s1_bypass <= eff_bypass;
        end
      end
    end
  end

  assign bus.out_valid      = s2_valid;
  assign bus.dct_coeffs_out = s2_data;
  assign bus.out_row        = {5'b0, s2_row};
  assign bus.block_done     = s2_valid && bus.out_ready && (s2_row == 3'd7);

endmodule

// File: tb/tb_dequantize_row.sv
// Randomized bench for dequantize_row against a queue-based arithmetic model.
module tb_dequantize_row;

  logic clock;
  logic reset_n;
  dequantize_row_if bus ();

  dequantize_row dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int luma_t [8][8] = '{
    '{16, 11, 10, 16, 24, 40, 51, 61},
    '{12, 12, 14, 19, 26, 58, 60, 55},
    '{14, 13, 16, 24, 40, 57, 69, 56},
    '{14, 17, 22, 29, 51, 87, 80, 62},
    '{18, 22, 37, 56, 68, 109, 103, 77},
    '{24, 35, 55, 64, 81, 104, 113, 92},
    '{49, 64, 78, 87, 103, 121, 120, 101},
    '{72, 92, 95, 98, 112, 100, 103, 99}
  };
  int chroma_t [8][8] = '{
    '{17, 18, 24, 47, 99, 99, 99, 99},
    '{18, 21, 26, 66, 99, 99, 99, 99},
    '{24, 26, 56, 99, 99, 99, 99, 99},
    '{47, 66, 99, 99, 99, 99, 99, 99},
    '{99, 99, 99, 99, 99, 99, 99, 99},
    '{99, 99, 99, 99, 99, 99, 99, 99},
    '{99, 99, 99, 99, 99, 99, 99, 99},
    '{99, 99, 99, 99, 99, 99, 99, 99}
  };

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [95:0] data;
    logic [2:0]  row;
    int          acc;
  } exp_t;
  exp_t q[$];

  int  cyc = 0;
  int  m_row = 0;
  bit  m_luma = 0;
  bit  m_bypass = 0;
  bit  post_rst = 0;
  int  exp_blocks = 0;
  int  n_pulses = 0;
  int  or_mode = 0;
  bit  stall_row2 = 0;
  bit  stalled_once = 0;

  task automatic chk_vec(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_coef(int r, int c, int x, bit lum, bit qo);
    int p;
    if (qo) return x;
    p = x * (lum ? luma_t[r][c] : chroma_t[r][c]);
`ifdef DEQUANT_SATURATE_EN
    if (p > 2047) p = 2047;
    if (p < -2048) p = -2048;
`else
    p = ((p % 4096) + 4096) % 4096;
    if (p >= 2048) p = p - 4096;
`endif
    return p;
  endfunction

  function automatic logic [95:0] model_row(int r, logic [79:0] d, bit lum, bit qo);
    logic [95:0] res;
    logic signed [9:0] xs;
    int x;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      xs = d[10*k +: 10];
      x = xs;
      res[12*k +: 12] = 12'(model_coef(r, k, x, lum, qo));
    end
    return res;
  endfunction

  // Per-cycle compare against the in-flight queue; also advances the model on handshakes.
  always @(negedge clock) begin
    bit exp_valid;
    bit exp_ready;
    bit exp_done;
    cyc++;
    if (!reset_n) begin
      chk_vec("in_ready_in_reset", 96'(bus.in_ready), 96'(0));
      q.delete();
      m_row = 0;
      post_rst = 1;
    end else begin
      if (post_rst) begin
        chk_vec("post_rst_out_valid", 96'(bus.out_valid), 96'(0));
        chk_vec("post_rst_data", bus.dct_coeffs_out, 96'(0));
        chk_vec("post_rst_out_row", 96'(bus.out_row), 96'(0));
        post_rst = 0;
      end
      exp_valid = (q.size() > 0) && (cyc - q[0].acc >= 2);
      chk_vec("out_valid", 96'(bus.out_valid), 96'(exp_valid));
      if (bus.out_valid && exp_valid) begin
        chk_vec("dct_coeffs_out", bus.dct_coeffs_out, q[0].data);
        chk_vec("out_row", 96'(bus.out_row), 96'(q[0].row));
      end
      exp_ready = (q.size() < 2) || bus.out_ready;
      chk_vec("in_ready", 96'(bus.in_ready), 96'(exp_ready));
      exp_done = bus.out_valid && bus.out_ready && exp_valid && (q[0].row == 3'd7);
      chk_vec("block_done", 96'(bus.block_done), 96'(exp_done));
      if (bus.block_done) n_pulses++;
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        if (q[0].row == 3'd7) exp_blocks++;
        void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        if (m_row == 0) begin
          m_luma = bus.is_luminance;
          m_bypass = bus.quantize_off;
        end
        q.push_back('{model_row(m_row, bus.quantized_in, m_luma, m_bypass), 3'(m_row), cyc});
        m_row = (m_row + 1) % 8;
      end
    end
  end

  // out_ready driver: always-1, random, or a 3-cycle stall when row 2 first appears
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (stall_row2 && !stalled_once && bus.out_valid && bus.out_row == 8'd2) begin
        stalled_once = 1;
        bus.out_ready = 1'b0;
        repeat (2) begin
          @(posedge clock);
          #1;
        end
        bus.out_ready = 1'b0;
      end else if (or_mode == 0)
        bus.out_ready = 1'b1;
      else
        bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [79:0] fill_row(int v);
    logic [79:0] r;
    for (int k = 0; k < 8; k++) r[10*k +: 10] = 10'(v);
    return r;
  endfunction

  function automatic logic [79:0] rand_row();
    logic [79:0] r;
    int unsigned s;
    for (int k = 0; k < 8; k++) begin
      s = $urandom_range(0, 7);
      if (s == 0) r[10*k +: 10] = 10'h200;
      else if (s == 1) r[10*k +: 10] = 10'h1FF;
      else r[10*k +: 10] = 10'($urandom);
    end
    return r;
  endfunction

  task automatic send_row(input logic [79:0] d, input logic lum, input logic qo);
    int unsigned n = 0;
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.quantized_in = d;
    bus.is_luminance = lum;
    bus.quantize_off = qo;
    while (!done) begin
      @(negedge clock);
      done = bus.in_ready;
      @(posedge clock);
      #1;
      n++;
      if (!done && n > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_row_timeout: in_ready never high within 200 cycles");
        done = 1;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    if (n > 0) begin
      bus.in_valid = 1'b0;
      bus.quantized_in = rand_row();
      bus.is_luminance = 1'($urandom);
      bus.quantize_off = 1'($urandom);
      repeat (n) @(posedge clock);
      #1;
    end
  endtask

  task automatic send_block(input logic lum, input logic qo, input logic [79:0] first,
                            input logic [79:0] mid, input bit rand_mid,
                            input logic [79:0] last, input int unsigned gap_max);
    for (int r = 0; r < 8; r++) begin
      if (r == 0) send_row(first, lum, qo);
      else send_row((r == 7) ? last : (rand_mid ? rand_row() : mid),
                    1'($urandom), 1'($urandom));
      idle($urandom_range(0, gap_max));
    end
  endtask

  int luma_r0_exp [8]   = '{16, 11, 10, 16, 24, 40, 51, 61};
  int chroma_m2_exp [8] = '{-34, -36, -48, -94, -198, -198, -198, -198};

  initial begin
    logic [79:0] last;
    int unsigned wait_n;
    bus.in_valid = 1'b0;
    bus.quantized_in = '0;
    bus.is_luminance = 1'b0;
    bus.quantize_off = 1'b0;
    reset_n = 1'b0;

    for (int k = 0; k < 8; k++) begin
      chk_int("pin_luma_r0", model_coef(0, k, 1, 1'b1, 1'b0), luma_r0_exp[k]);
      chk_int("pin_chroma_m2", model_coef(0, k, -2, 1'b0, 1'b0), chroma_m2_exp[k]);
    end
`ifdef DEQUANT_SATURATE_EN
    chk_int("pin_sat_pos", model_coef(7, 7, 511, 1'b1, 1'b0), 2047);
    chk_int("pin_sat_neg", model_coef(7, 7, -512, 1'b1, 1'b0), -2048);
`else
    chk_int("pin_wrap_pos", model_coef(7, 7, 511, 1'b1, 1'b0), 1437);
    chk_int("pin_wrap_neg", model_coef(7, 7, -512, 1'b1, 1'b0), -1536);
`endif
    chk_int("pin_bypass", model_coef(3, 2, -5, 1'b1, 1'b1), -5);

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    or_mode = 0;
    send_block(1'b1, 1'b0, fill_row(1), '0, 1, rand_row(), 1);
    send_block(1'b0, 1'b0, fill_row(-2), '0, 1, rand_row(), 1);
    last = rand_row();
    last[79:70] = 10'h1FF;
    send_block(1'b1, 1'b0, rand_row(), '0, 1, last, 0);
    last[79:70] = 10'h200;
    send_block(1'b1, 1'b0, rand_row(), '0, 1, last, 0);
    send_block(1'b1, 1'b1, fill_row(-5), fill_row(-5), 0, fill_row(-5), 1);

    stall_row2 = 1;
    stalled_once = 0;
    send_block(1'b1, 1'b0, rand_row(), '0, 1, rand_row(), 0);
    idle(6);
    stall_row2 = 0;

    or_mode = 1;
    repeat (12) send_block(1'($urandom), 1'($urandom), rand_row(), '0, 1, rand_row(), 2);

    for (int r = 0; r < 3; r++) send_row(rand_row(), 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    send_block(1'b0, 1'b0, rand_row(), '0, 1, rand_row(), 1);

    or_mode = 0;
    idle(1);
    wait_n = 0;
    while (q.size() > 0 && wait_n < 200) begin
      @(posedge clock);
      #1;
      wait_n++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d rows still pending, expected 0", q.size());
    end
    chk_int("block_done_pulses", n_pulses, exp_blocks);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
